core_seq: RTL and testbench

Multi-cycle sequencer for the single-issue L1 core. It walks each instruction through fetch, decode, execute, memory and writeback by driving the per-stage `i_sys_ready` inputs and consuming each stage's `o_sys_valid`. It latches the decoded memory and halt intent at the end of decode, so the memory stage is skipped for non-memory instructions. It also keeps cycle and retired-instruction counters, and flags a stuck memory access.

---
 rtl/core_pkg.sv | 33 +++
 rtl/seq_cnt.sv | 39 +++
 rtl/core_seq.sv | 173 +++++++++++++++++
 tb/tb_core_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core sequencer.
//   seq_state_t    - sequencer state encoding, exported on o_state
//   ARGS_WIDTH     - width of the decoded writeback-source field
//   REG_WR_SRC_*   - writeback-source encodings; only MEM matters here
//   CNT_WIDTH_DEF  - default width of the performance counters
package core_pkg;

  localparam int ARGS_WIDTH    = 3;
  localparam int CNT_WIDTH_DEF = 32;

  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_ALU = 3'd0;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_MEM = 3'd1;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_PC  = 3'd2;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_CSR = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_LS   = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6,
    ST_ERR  = 3'd7
  } seq_state_t;

  // True for the states in which an instruction is in flight.
  function automatic logic is_active(seq_state_t s);
    return (s == ST_IF) || (s == ST_ID) || (s == ST_EX) ||
           (s == ST_LS) || (s == ST_WB);
  endfunction

endpackage

// File: rtl/seq_cnt.sv
// seq_cnt: up-counter with enable, synchronous clear and natural wrap.
//   i_clk  - clock
//   i_rst  - synchronous active-high reset (clears the count)
//   i_clr  - synchronous clear, has priority over i_en
//   i_en   - count enable
//   o_cnt  - current count, wraps modulo 2^W
module seq_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle sequencer walking each instruction through
// IF -> ID -> EX -> (LS) -> WB, with HALT/ERR absorbing states.
//   i_sys_clk / i_sys_rst          - clock, synchronous active-high reset
//   i_sys_start                    - leaves IDLE
//   i_ifu/idu/exu/lsu_valid        - per-stage completion handshakes
//   i_idu_ctr_ram_wr_en            - decoded store
//   i_idu_ctr_reg_wr_src           - decoded writeback source
//   i_idu_end_flag                 - decoded halt (EBREAK)
//   o_ifu/idu/exu/lsu_ready        - one-hot decode of the current stage
//   o_wbu_commit                   - single-cycle commit pulse in WB
//   o_halt / o_err                 - sticky halt / LSU-timeout flags
//   o_state                        - current state encoding
//   o_cyc_cnt / o_inst_cnt         - active cycles / retired instructions
module core_seq
  import core_pkg::*;
#(
  parameter int LSU_TMO   = 255,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_sys_start,
  input  logic                  i_ifu_valid,
  input  logic                  i_idu_valid,
  input  logic                  i_exu_valid,
  input  logic                  i_lsu_valid,
  input  logic                  i_idu_ctr_ram_wr_en,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_reg_wr_src,
  input  logic                  i_idu_end_flag,
  output logic                  o_ifu_ready,
  output logic                  o_idu_ready,
  output logic                  o_exu_ready,
  output logic                  o_lsu_ready,
  output logic                  o_wbu_commit,
  output logic                  o_halt,
  output logic                  o_err,
  output logic [2:0]            o_state,
  output logic [CNT_WIDTH-1:0]  o_cyc_cnt,
  output logic [CNT_WIDTH-1:0]  o_inst_cnt
);

  // The wait counter only ever reaches LSU_TMO-1 before LS is left.
  localparam int WAIT_W = (LSU_TMO < 2) ? 1 : $clog2(LSU_TMO + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LSU_TMO - 1);

  seq_state_t state_q, state_d;
  logic       mem_q, mem_d;
  logic       end_q, end_d;
  logic       halt_q, halt_d;
  logic       err_q, err_d;

  logic [WAIT_W-1:0] wait_cnt;
  logic              id_exit;
  logic              lsu_timeout;

  assign id_exit     = (state_q == ST_ID) && i_idu_valid;
  // A valid in the timeout cycle takes priority, so timeout needs it low.
  assign lsu_timeout = (state_q == ST_LS) && !i_lsu_valid && (wait_cnt == WAIT_LAST);

  // ---------------------------------------------------------------
  // Decode intent latched at the ID exit, held until the next exit.
  // ---------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    end_d = end_q;
    if (id_exit) begin
      mem_d = i_idu_ctr_ram_wr_en | (i_idu_ctr_reg_wr_src == REG_WR_SRC_MEM);
      end_d = i_idu_end_flag;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_sys_start) state_d = ST_IF;
      ST_IF:   if (i_ifu_valid) state_d = ST_ID;
      // end_d is the freshly latched halt flag on the exit edge.
      ST_ID:   if (i_idu_valid) state_d = end_d ? ST_HALT : ST_EX;
      ST_EX:   if (i_exu_valid) state_d = mem_q ? ST_LS : ST_WB;
      ST_LS: begin
        if (i_lsu_valid) begin
          state_d = ST_WB;
        end else if (lsu_timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags rise together with the state they announce.
  always_comb begin
    halt_d = halt_q | (state_d == ST_HALT);
    err_d  = err_q  | (state_d == ST_ERR);
  end

  // ---------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      mem_q   <= 1'b0;
      end_q   <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      end_q   <= end_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------
  // Outputs: pure decode of the registered state
  // ---------------------------------------------------------------
  always_comb begin
    o_ifu_ready  = 1'b0;
    o_idu_ready  = 1'b0;
    o_exu_ready  = 1'b0;
    o_lsu_ready  = 1'b0;
    o_wbu_commit = 1'b0;
    unique case (state_q)
      ST_IF:   o_ifu_ready  = 1'b1;
      ST_ID:   o_idu_ready  = 1'b1;
      ST_EX:   o_exu_ready  = 1'b1;
      ST_LS:   o_lsu_ready  = 1'b1;
      ST_WB:   o_wbu_commit = 1'b1;
      default: ;
    endcase
  end

  assign o_halt  = halt_q;
  assign o_err   = err_q;
  assign o_state = state_q;

  // ---------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------
  seq_cnt #(.W(CNT_WIDTH)) u_cyc_cnt (
    .i_clk (i_sys_clk),
    .i_rst (i_sys_rst),
    .i_clr (1'b0),
    .i_en  (is_active(state_q)),
    .o_cnt (o_cyc_cnt)
  );

  seq_cnt #(.W(CNT_WIDTH)) u_inst_cnt (
    .i_clk (i_sys_clk),
    .i_rst (i_sys_rst),
    .i_clr (1'b0),
    .i_en  (state_q == ST_WB),
    .o_cnt (o_inst_cnt)
  );

  // Held at zero outside LS, so every LS visit starts from zero.
  seq_cnt #(.W(WAIT_W)) u_wait_cnt (
    .i_clk (i_sys_clk),
    .i_rst (i_sys_rst),
    .i_clr (state_q != ST_LS),
    .i_en  ((state_q == ST_LS) && !i_lsu_valid),
    .o_cnt (wait_cnt)
  );

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: randomized bench for core_seq. A per-cycle plan of expected
// states is built from instruction-level rules (stage delays, memory/halt
// intent, timeout), then replayed while all outputs are checked each cycle.
module tb_core_seq;
  import core_pkg::*;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
                         S_LS = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;

  logic clk = 1'b0;
  logic rst, start, ifu_v, idu_v, exu_v, lsu_v, wr_en, end_flag;
  logic [ARGS_WIDTH-1:0] wr_src;
  logic ifu_r, idu_r, exu_r, lsu_r, commit, halt, err;
  logic [2:0] state;
  logic [CW-1:0] cyc_cnt, inst_cnt;

  core_seq #(.LSU_TMO(TMO), .CNT_WIDTH(CW)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_sys_start(start),
    .i_ifu_valid(ifu_v), .i_idu_valid(idu_v), .i_exu_valid(exu_v), .i_lsu_valid(lsu_v),
    .i_idu_ctr_ram_wr_en(wr_en), .i_idu_ctr_reg_wr_src(wr_src), .i_idu_end_flag(end_flag),
    .o_ifu_ready(ifu_r), .o_idu_ready(idu_r), .o_exu_ready(exu_r), .o_lsu_ready(lsu_r),
    .o_wbu_commit(commit), .o_halt(halt), .o_err(err), .o_state(state),
    .o_cyc_cnt(cyc_cnt), .o_inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]            st;
    bit                    fire;
    bit                    start;
    bit                    rst;
    bit                    wr;
    logic [ARGS_WIDTH-1:0] src;
    bit                    endf;
  } cyc_t;

  cyc_t plan[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc_idx = 0;
  int   retired = 0;

  task automatic push(logic [2:0] st, bit fire, bit st_start = 0, bit st_rst = 0,
                      bit wr = 0, logic [ARGS_WIDTH-1:0] src = '0, bit endf = 0);
    cyc_t c;
    c.st = st; c.fire = fire; c.start = st_start; c.rst = st_rst;
    c.wr = wr; c.src = src; c.endf = endf;
    plan.push_back(c);
  endtask

  // n cycles in a stage, handshake on the last one.
  task automatic push_seg(logic [2:0] st, int n);
    for (int i = 0; i < n; i++) push(st, i == n - 1);
  endtask

  // Absorbing state held for a while (start wiggled), left by reset.
  task automatic push_tail(logic [2:0] st);
    for (int i = 0; i < 5; i++) push(st, 0, 1'($urandom_range(0, 1)), i == 4);
  endtask

  task automatic push_launch(int idle_cycles);
    for (int i = 0; i < idle_cycles; i++) push(S_IDLE, 0, 0, 0);
    push(S_IDLE, 0, 1, 0);
  endtask

  // One instruction; term=1 when it ends in HALT/ERR/reset (tail included).
  task automatic push_instr(bit wr, logic [ARGS_WIDTH-1:0] src, bit endf,
                            int dif, int did, int dex, int dls, bit rst_in_ls,
                            output bit term);
    bit mem;
    term = 0;
    push_seg(S_IF, dif + 1);
    for (int i = 0; i <= did; i++) push(S_ID, i == did, 0, 0, wr, src, endf);
    if (endf) begin
      push_tail(S_HALT);
      term = 1;
      return;
    end
    push_seg(S_EX, dex + 1);
    mem = wr || (src == REG_WR_SRC_MEM);
    if (mem) begin
      if (rst_in_ls) begin
        push(S_LS, 0, 0, 1);
        term = 1;
        return;
      end
      if (dls >= TMO) begin
        for (int i = 0; i < TMO; i++) push(S_LS, 0);
        push_tail(S_ERR);
        term = 1;
        return;
      end
      push_seg(S_LS, dls + 1);
    end
    push(S_WB, 0);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_idx, obs, exp);
  endtask

  function automatic logic [ARGS_WIDTH-1:0] non_mem_src();
    logic [ARGS_WIDTH-1:0] s;
    s = ARGS_WIDTH'($urandom);
    if (s == REG_WR_SRC_MEM) s = REG_WR_SRC_ALU;
    return s;
  endfunction

  initial begin
    bit term;
    logic [CW-1:0] exp_cyc;
    logic [CW-1:0] exp_inst;
    int kind;

    rst = 1; start = 0; ifu_v = 0; idu_v = 0; exu_v = 0; lsu_v = 0;
    wr_en = 0; wr_src = '0; end_flag = 0;

    // ADDI with zero delays, then LW with LSU response on the 4th LS cycle,
    // then a store reset in its LS cycle.
    push_launch(2);
    push_instr(0, REG_WR_SRC_ALU, 0, 0, 0, 0, 0, 0, term);
    push_instr(0, REG_WR_SRC_MEM, 0, 0, 0, 0, 3, 0, term);
    push_instr(1, REG_WR_SRC_ALU, 0, 0, 0, 0, 0, 1, term);
    // Two ADDIs then EBREAK.
    push_launch(1);
    push_instr(0, REG_WR_SRC_ALU, 0, 1, 0, 2, 0, 0, term);
    push_instr(0, REG_WR_SRC_PC,  0, 0, 1, 0, 0, 0, term);
    push_instr(0, REG_WR_SRC_ALU, 1, 0, 0, 0, 0, 0, term);
    // LW whose response never comes: timeout.
    push_launch(1);
    push_instr(0, REG_WR_SRC_MEM, 0, 0, 0, 0, 100, 0, term);
    // 17 ADDIs: instruction counter wraps to 1.
    push_launch(0);
    for (int i = 0; i < 17; i++)
      push_instr(0, non_mem_src(), 0, $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), 0, 0, term);
    // Random mix.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 19);
      if (kind < 8)
        push_instr(0, non_mem_src(), 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 0, 0, term);
      else if (kind < 13)
        push_instr(0, REG_WR_SRC_MEM, 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 5), 0, term);
      else if (kind < 18)
        push_instr(1, ARGS_WIDTH'($urandom), 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 5), 0, term);
      else
        push_instr(0, non_mem_src(), 1, 0, $urandom_range(0, 2), 0, 0, 0, term);
      if (term) push_launch($urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    exp_cyc  = '0;
    exp_inst = '0;

    foreach (plan[k]) begin
      cyc_t c;
      c = plan[k];
      chk("state",  32'(state), 32'(c.st));
      chk("ready",  32'({ifu_r, idu_r, exu_r, lsu_r}),
          32'({c.st == S_IF, c.st == S_ID, c.st == S_EX, c.st == S_LS}));
      chk("commit", 32'(commit), 32'(c.st == S_WB));
      chk("halt",   32'(halt),   32'(c.st == S_HALT));
      chk("err",    32'(err),    32'(c.st == S_ERR));
      chk("cyc_cnt",  32'(cyc_cnt),  32'(exp_cyc));
      chk("inst_cnt", 32'(inst_cnt), 32'(exp_inst));
      if (c.st == S_WB) begin
        retired++;
        $display("retire #%0d at cycle %0d inst_cnt=%0d cyc_cnt=%0d", retired, cyc_idx,
                 inst_cnt, cyc_cnt);
      end

      rst   = c.rst;
      start = (c.st == S_IDLE) ? c.start : 1'($urandom_range(0, 1));
      ifu_v = (c.st == S_IF) ? c.fire : 1'($urandom_range(0, 1));
      idu_v = (c.st == S_ID) ? c.fire : 1'($urandom_range(0, 1));
      exu_v = (c.st == S_EX) ? c.fire : 1'($urandom_range(0, 1));
      lsu_v = (c.st == S_LS) ? c.fire : 1'($urandom_range(0, 1));
      if (c.st == S_ID && c.fire) begin
        wr_en = c.wr; wr_src = c.src; end_flag = c.endf;
      end else begin
        wr_en = 1'($urandom_range(0, 1));
        wr_src = ARGS_WIDTH'($urandom);
        end_flag = 1'($urandom_range(0, 1));
      end

      if (c.rst) begin
        exp_cyc  = '0;
        exp_inst = '0;
      end else begin
        if (c.st >= S_IF && c.st <= S_WB) exp_cyc = exp_cyc + 1'b1;
        if (c.st == S_WB) exp_inst = exp_inst + 1'b1;
      end
      cyc_idx++;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
